vji_debug_initiator: RTL

- Drives the virtual-JTAG side of the Nios II debug slave from on-chip logic, replacing the JTAG hub as the initiator.
- Accepts one command (IR value plus a DATA_W-bit data word) on a valid/ready interface.
- Generates the tck, tdi, ir_in and virtual-state strobe sequence UIR -> CDR -> SDR x DATA_W -> UDR -> RTI.
- Captures tdo during the shift and ir_out during UIR, then returns both on a one-cycle response strobe.

---
 rtl/vji_debug_initiator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vji_debug_initiator.sv
// On-chip initiator for the Nios II virtual-JTAG debug slave: runs one
// UIR -> CDR -> SDR x DATA_W -> UDR -> RTI sequence per accepted command.
module vji_debug_initiator #(
  parameter int DATA_W   = 38,
  parameter int IR_W     = 2,
  parameter int TCK_DIV  = 2,
  parameter int RTI_TCKS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_W-1:0]   cmd_ir,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [IR_W-1:0]   rsp_ir,
  output logic              busy,
  output logic              tck,
  output logic              tdi,
  input  logic              tdo,
  output logic [IR_W-1:0]   ir_in,
  input  logic [IR_W-1:0]   ir_out,
  output logic              vs_uir,
  output logic              vs_cdr,
  output logic              vs_sdr,
  output logic              vs_udr,
  output logic              jtag_state_rti
);

  localparam int PC_W  = ($clog2(2*TCK_DIV) > 0) ? $clog2(2*TCK_DIV) : 1;
  localparam int BIT_W = ($clog2(DATA_W) > 0) ? $clog2(DATA_W) : 1;
  localparam int RTI_W = (RTI_TCKS > 1) ? $clog2(RTI_TCKS) : 1;

  localparam logic [PC_W-1:0]  PC_PRE_RISE = PC_W'(TCK_DIV - 1);
  localparam logic [PC_W-1:0]  PC_HIGH     = PC_W'(TCK_DIV);
  localparam logic [PC_W-1:0]  PC_LAST     = PC_W'(2*TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);
  localparam logic [RTI_W-1:0] RTI_LAST    = RTI_W'((RTI_TCKS > 0) ? RTI_TCKS - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI} state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [RTI_W-1:0]  rti_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] cap;
  logic              accept, done;
  logic              period_end, rise;

  // rise marks the clk whose edge takes tck high; period_end is the only advance point.
  assign period_end = (state != S_IDLE) && (pc == PC_LAST);
  assign rise       = (state != S_IDLE) && (pc == PC_PRE_RISE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = '0;
    accept         = 1'b0;
    done           = 1'b0;
    cmd_ready      = (state == S_IDLE);
    busy           = (state != S_IDLE);
    vs_uir         = (state == S_UIR);
    vs_cdr         = (state == S_CDR);
    vs_sdr         = (state == S_SDR);
    vs_udr         = (state == S_UDR);
    jtag_state_rti = (state == S_RTI);
    tdi            = (state == S_SDR) && shift_reg[0];

    if (state == S_IDLE) begin
      if (cmd_valid) begin
        accept     = 1'b1;
        state_next = S_UIR;
      end
    end else begin
      pc_next = period_end ? '0 : pc + PC_W'(1);
    end

    if (period_end) begin
      case (state)
        S_UIR: state_next = S_CDR;
        S_CDR: state_next = S_SDR;
        S_SDR: if (bit_cnt == BIT_LAST) state_next = S_UDR;
        S_UDR: begin
          if (RTI_TCKS == 0) begin
            state_next = S_IDLE;
            done       = 1'b1;
          end else begin
            state_next = S_RTI;
          end
        end
        S_RTI: begin
          if (rti_cnt == RTI_LAST) begin
            state_next = S_IDLE;
            done       = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tck       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ir    <= '0;
      ir_in     <= '0;
      shift_reg <= '0;
      cap       <= '0;
      bit_cnt   <= '0;
      rti_cnt   <= '0;
    end else begin
      tck       <= (pc_next >= PC_HIGH);
      rsp_valid <= done;
      if (accept) begin
        ir_in     <= cmd_ir;
        shift_reg <= cmd_data;
        cap       <= '0;
        bit_cnt   <= '0;
        rti_cnt   <= '0;
      end
      if (rise && state == S_UIR)
        rsp_ir <= ir_out;
      // Capture enters at the MSB so the first shifted bit ends up in bit 0.
      if (rise && state == S_SDR)
        cap <= {tdo, cap[DATA_W-1:1]};
      if (period_end && state == S_SDR) begin
        shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
        bit_cnt   <= bit_cnt + BIT_W'(1);
      end
      if (period_end && state == S_RTI)
        rti_cnt <= rti_cnt + RTI_W'(1);
      if (done)
        rsp_data <= cap;
    end
  end

endmodule
